// File: rtl/snn_config_sync.sv
// snn_config_sync
// Core-clock consumer of the SPI configuration image. It synchronises the
// SCLK-domain ready flags, stages each new image, and loads the staged image
// into the active copy only on a time-step boundary. When the divider is
// stopped, the load happens straight away. It also derives the core
// time-step tick from the programmed divider value.
//
// Ports
//   clk                       core clock
//   reset_n                   async active-low reset
//   config_in[807:0]          configuration image from the SCLK domain (quasi-static)
//   clk_div_ready_async       SCLK flag: divider byte (byte 3) valid
//   debug_config_ready_async  SCLK flag: full image valid
//   decay / refractory_period / threshold / weights / delays / debug_config
//                             active copy of the image fields
//   div_value                 captured divider value
//   snn_tick                  one-cycle time-step pulse, period div_value+1
//   config_pending            a staged image is waiting for a step boundary
//   config_update             one-cycle pulse when the active copy is loaded
//   config_valid              sticky, at least one image has been loaded
//
// Staging FSM
//   state   | meaning
//   IDLE    | no staged image awaiting transfer
//   PENDING | staging holds an image to load at the next boundary
module snn_config_sync (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [807:0] config_in,
    input  logic         clk_div_ready_async,
    input  logic         debug_config_ready_async,
    output logic [5:0]   decay,
    output logic [5:0]   refractory_period,
    output logic [5:0]   threshold,
    output logic [255:0] weights,
    output logic [511:0] delays,
    output logic [7:0]   debug_config,
    output logic [7:0]   div_value,
    output logic         snn_tick,
    output logic         config_pending,
    output logic         config_update,
    output logic         config_valid
);

    // Only the bits that reach an output are staged. The image is packed as
    // {debug, delays, weights, threshold, refractory, decay}.
    localparam int IMG_W = 794;

    typedef enum logic {IDLE, PENDING} state_t;

    logic div_s1_q, div_s2_q, div_prev_q;
    logic dbg_s1_q, dbg_s2_q, dbg_prev_q;
    logic div_rise, div_fall, dbg_rise;

    logic [7:0] div_value_q, div_value_d;
    logic [7:0] cnt_q, cnt_d;
    logic       run_q, run_d;
    logic       tick_q, tick_d;

    state_t           state_q, state_d;
    logic [IMG_W-1:0] img_in;
    logic [IMG_W-1:0] stage_q, stage_d;
    logic [IMG_W-1:0] active_q, active_d;
    logic             update_q, update_d;
    logic             valid_q, valid_d;
    logic             transfer;

    // Padding bits of bytes 0..2 carry no field.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{config_in[7:6], config_in[15:14], config_in[23:22]};

    assign img_in = {config_in[807:32], config_in[21:16], config_in[13:8], config_in[5:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_s1_q   <= 1'b0;
            div_s2_q   <= 1'b0;
            div_prev_q <= 1'b0;
            dbg_s1_q   <= 1'b0;
            dbg_s2_q   <= 1'b0;
            dbg_prev_q <= 1'b0;
        end else begin
            div_s1_q   <= clk_div_ready_async;
            div_s2_q   <= div_s1_q;
            div_prev_q <= div_s2_q;
            dbg_s1_q   <= debug_config_ready_async;
            dbg_s2_q   <= dbg_s1_q;
            dbg_prev_q <= dbg_s2_q;
        end
    end

    assign div_rise = div_s2_q & ~div_prev_q;
    assign div_fall = ~div_s2_q & div_prev_q;
    assign dbg_rise = dbg_s2_q & ~dbg_prev_q;

    // Divider: a recapture restarts the count at 0 and suppresses the tick on
    // that edge, so a new period always starts cleanly.
    always_comb begin
        div_value_d = div_value_q;
        cnt_d       = cnt_q;
        run_d       = run_q;
        tick_d      = 1'b0;
        if (div_rise) begin
            div_value_d = config_in[31:24];
            cnt_d       = 8'd0;
            run_d       = 1'b1;
        end else if (div_fall) begin
            cnt_d = 8'd0;
            run_d = 1'b0;
        end else if (run_q) begin
            if (cnt_q == div_value_q) begin
                tick_d = 1'b1;
                cnt_d  = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_value_q <= 8'd0;
            cnt_q       <= 8'd0;
            run_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            div_value_q <= div_value_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            tick_q      <= tick_d;
        end
    end

    // The transfer happens on the edge where the registered tick is high, so
    // the active copy changes exactly at the step boundary. A capture on the
    // same edge reloads staging after the old staged image has moved to the
    // active copy, which keeps the FSM in PENDING.
    assign transfer = (state_q == PENDING) && (tick_q || !run_q);

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        active_d = active_q;
        update_d = 1'b0;
        valid_d  = valid_q;
        if (transfer) begin
            active_d = stage_q;
            update_d = 1'b1;
            valid_d  = 1'b1;
            state_d  = IDLE;
        end
        if (dbg_rise) begin
            stage_d = img_in;
            state_d = PENDING;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            active_q <= '0;
            update_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            active_q <= active_d;
            update_q <= update_d;
            valid_q  <= valid_d;
        end
    end

    assign decay             = active_q[5:0];
    assign refractory_period = active_q[11:6];
    assign threshold         = active_q[17:12];
    assign weights           = active_q[273:18];
    assign delays            = active_q[785:274];
    assign debug_config      = active_q[793:786];
    assign div_value         = div_value_q;
    assign snn_tick          = tick_q;
    assign config_pending    = (state_q == PENDING);
    assign config_update     = update_q;
    assign config_valid      = valid_q;

endmodule
